display_bcd_seq: RTL

Sequential, parametrised binary-to-decimal 7-segment display driver. It converts a WIDTH-bit unsigned value to DIGITS BCD digits using iterative shift-and-add-3 (double dabble), one bit per clock. It adds a start/busy/done handshake, leading-zero blanking and overflow indication. The block sits between the ALU result bus and the board's active-low HEX displays, and scales to any operand width.

---
 rtl/display_bcd_seq.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/display_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) driving
// active-low 7-segment displays with leading-zero blanking and overflow dashes.

module display_bcd_seg (
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'b0111111;
        if (dash)
            seg = 7'b0111111;
        else if (blank)
            seg = 7'b1111111;
        else begin
            case (digit)
                4'd0:    seg = 7'b1000000;
                4'd1:    seg = 7'b1111001;
                4'd2:    seg = 7'b0100100;
                4'd3:    seg = 7'b0110000;
                4'd4:    seg = 7'b0011001;
                4'd5:    seg = 7'b0010010;
                4'd6:    seg = 7'b0000010;
                4'd7:    seg = 7'b1111000;
                4'd8:    seg = 7'b0000000;
                4'd9:    seg = 7'b0010000;
                default: seg = 7'b0111111;
            endcase
        end
    end
endmodule

module display_bcd_seq #(
    parameter int WIDTH    = 16,
    parameter int DIGITS   = 5,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   hex
);
    localparam int BW   = 4 * DIGITS;
    localparam int SW   = BW + WIDTH;
    localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CMPW = (WIDTH > BW + 4) ? WIDTH : BW + 4;

    // 10^DIGITS < 2^(4*DIGITS), so CMPW bits never wrap even for wide DIGITS
    function automatic logic [CMPW-1:0] max_val();
        logic [CMPW-1:0] p;
        p = CMPW'(1);
        for (int i = 0; i < DIGITS; i++)
            p = p * CMPW'(10);
        return p - CMPW'(1);
    endfunction

    function automatic logic [7*DIGITS-1:0] hex_rst();
        logic [7*DIGITS-1:0] h;
        h = '0;
        for (int i = 0; i < DIGITS; i++)
            h[7*i +: 7] = (i == 0 || BLANK_LZ == 0) ? 7'b1000000 : 7'b1111111;
        return h;
    endfunction

    localparam logic [CMPW-1:0]     MAXV    = max_val();
    localparam logic [7*DIGITS-1:0] HEX_RST = hex_rst();

    typedef enum logic [0:0] {IDLE, SHIFT} state_t;

    state_t              state;
    logic [SW-1:0]       sr;
    logic [SW-1:0]       sr_adj;
    logic [SW-1:0]       sr_nxt;
    logic [CW-1:0]       cnt;
    logic                ovf_pend;
    logic [BW-1:0]       bcd_fin;
    logic [7*DIGITS-1:0] hex_nxt;
    logic [DIGITS:1]     hi_zero;

    // add-3 correction on every BCD nibble, then a single left shift
    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr[WIDTH + 4*i +: 4] >= 4'd5)
                sr_adj[WIDTH + 4*i +: 4] = sr[WIDTH + 4*i +: 4] + 4'd3;
        end
        sr_nxt = {sr_adj[SW-2:0], 1'b0};
    end

    assign bcd_fin         = sr_nxt[SW-1 -: BW];
    assign hi_zero[DIGITS] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        logic blank_i;
        if (i == 0) begin : g_units
            assign blank_i = 1'b0;
        end else begin : g_upper
            if (i < DIGITS - 1) begin : g_chain
                assign hi_zero[i] = hi_zero[i+1] & (bcd_fin[4*i +: 4] == 4'd0);
            end else begin : g_top
                assign hi_zero[i] = (bcd_fin[4*i +: 4] == 4'd0);
            end
            assign blank_i = (BLANK_LZ != 0) && hi_zero[i];
        end
        display_bcd_seg u_seg (
            .digit (bcd_fin[4*i +: 4]),
            .blank (blank_i),
            .dash  (ovf_pend),
            .seg   (hex_nxt[7*i +: 7])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sr       <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            bcd      <= '0;
            hex      <= HEX_RST;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr       <= {{BW{1'b0}}, bin};
                        cnt      <= CW'(WIDTH - 1);
                        ovf_pend <= (CMPW'(bin) > MAXV);
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr <= sr_nxt;
                    if (cnt == '0) begin
                        bcd   <= bcd_fin;
                        hex   <= hex_nxt;
                        ovf   <= ovf_pend;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
